// File: rtl/tsip_time_parser.sv
// TSIP primary timing packet (0x8F-AB) decoder: strips DLE framing/stuffing, buffers the
// payload in a shadow array and commits the UTC time/date fields atomically on a good DLE-ETX.
module tsip_time_parser #(
    parameter int TIMEOUT_CLKS = 20000,
    parameter int PAYLOAD_LEN  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_seconds,
    output logic [7:0] o_minutes,
    output logic [7:0] o_hour,
    output logic [7:0] o_day,
    output logic [7:0] o_month,
    output logic [7:0] o_year_0,
    output logic [7:0] o_year_1,
    output logic [7:0] o_flags,
    output logic       o_time_valid,
    output logic       o_pkt_err
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int CW = $clog2(PAYLOAD_LEN + 1);

    localparam logic [7:0] DLE      = 8'h10;
    localparam logic [7:0] ETX      = 8'h03;
    localparam logic [7:0] ID_TIME  = 8'h8F;
    localparam logic [7:0] SUB_TIME = 8'hAB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_SUB,
        S_DATA,
        S_DATA_DLE,
        S_SKIP,
        S_SKIP_DLE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            w_timeout;
    logic            w_wr_en;
    logic [7:0]      w_wr_data;
    logic            w_commit;
    logic            w_err;
    logic [7:0]      r_shadow [PAYLOAD_LEN];
    logic [7:0]      r_time   [8];
    logic            r_time_valid;
    logic            r_pkt_err;

    // i_rx_valid is a one-cycle strobe with no back-pressure: every strobed byte is consumed
    // in that cycle, and a strobe in the terminal timeout cycle takes precedence over the abort.
    assign w_timeout = !i_rx_valid && (r_state != S_IDLE) &&
                       (r_to_cnt == TW'(TIMEOUT_CLKS - 1));

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_wr_en      = 1'b0;
        w_wr_data    = i_rx_byte;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        if (i_rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_byte == DLE) w_next_state = S_ID;
                end
                S_ID: begin
                    if (i_rx_byte == ID_TIME)                         w_next_state = S_SUB;
                    else if ((i_rx_byte == DLE) || (i_rx_byte == ETX)) w_next_state = S_IDLE;
                    else                                              w_next_state = S_SKIP;
                end
                S_SUB: begin
                    if (i_rx_byte == SUB_TIME) begin
                        w_next_state = S_DATA;
                        w_next_cnt   = '0;
                    end else if (i_rx_byte == DLE) begin
                        w_next_state = S_SKIP_DLE;
                    end else begin
                        w_next_state = S_SKIP;
                    end
                end
                S_DATA: begin
                    if (i_rx_byte == DLE) begin
                        w_next_state = S_DATA_DLE;
                    end else if (r_cnt == CW'(PAYLOAD_LEN)) begin
                        w_err        = 1'b1;
                        w_next_state = S_SKIP;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_next_cnt = r_cnt + CW'(1);
                    end
                end
                S_DATA_DLE: begin
                    if (i_rx_byte == DLE) begin
                        // Stuffed DLE is payload, and still subject to the overflow limit.
                        if (r_cnt == CW'(PAYLOAD_LEN)) begin
                            w_err        = 1'b1;
                            w_next_state = S_SKIP;
                        end else begin
                            w_wr_en      = 1'b1;
                            w_wr_data    = DLE;
                            w_next_cnt   = r_cnt + CW'(1);
                            w_next_state = S_DATA;
                        end
                    end else if (i_rx_byte == ETX) begin
                        w_next_state = S_IDLE;
                        if (r_cnt == CW'(PAYLOAD_LEN)) w_commit = 1'b1;
                        else                           w_err    = 1'b1;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (i_rx_byte == DLE) w_next_state = S_SKIP_DLE;
                end
                S_SKIP_DLE: begin
                    if (i_rx_byte == ETX) w_next_state = S_IDLE;
                    else                  w_next_state = S_SKIP;
                end
                default: w_next_state = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_next_state = S_IDLE;
            w_err = (r_state == S_SUB) || (r_state == S_DATA) || (r_state == S_DATA_DLE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_time_valid <= 1'b0;
            r_pkt_err    <= 1'b0;
            for (int i = 0; i < 8; i++) r_time[i] <= 8'h00;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_time_valid <= w_commit;
            r_pkt_err    <= w_err;
            if (i_rx_valid || w_timeout) r_to_cnt <= '0;
            else if (r_state != S_IDLE)  r_to_cnt <= r_to_cnt + TW'(1);
            if (w_commit) begin
                for (int i = 0; i < 8; i++) r_time[i] <= r_shadow[8 + i];
            end
        end
    end

    // Shadow holds the in-flight payload; outputs only change on commit.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (w_wr_en && (r_cnt == CW'(i))) r_shadow[i] <= w_wr_data;
        end
    end

    assign o_flags      = r_time[0];
    assign o_seconds    = r_time[1];
    assign o_minutes    = r_time[2];
    assign o_hour       = r_time[3];
    assign o_day        = r_time[4];
    assign o_month      = r_time[5];
    assign o_year_0     = r_time[6];
    assign o_year_1     = r_time[7];
    assign o_time_valid = r_time_valid;
    assign o_pkt_err    = r_pkt_err;

endmodule
